// File: rtl/truth_table_checker_pkg.sv
// Shared definitions for the truth-table checker: FSM state encodings,
// the state type, and a helper for the vector count of an N-input DUT.
package truth_table_checker_pkg;

  // FSM state type and encodings. These values appear on the dbg_state
  // output so a checker or waveform viewer can decode them directly.
  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE  = 2'd0;
  localparam state_t ST_DRIVE = 2'd1;
  localparam state_t ST_DONE  = 2'd2;

  // Number of input vectors an N-input combinational DUT has (2**n_in).
  function automatic int num_vectors(input int n_in);
    return 1 << n_in;
  endfunction

endpackage

// File: rtl/truth_table_checker_if.sv
// Bundle of control, stimulus and result signals between the truth-table
// checker (slave side) and whatever starts it and hosts the DUT (master side).
//
// Handshake: start is a single-cycle-or-level request with no ready signal.
// It is accepted on any rising clk edge where the checker is in IDLE or DONE;
// while busy is high start is ignored. Acceptance is visible one cycle later
// as busy=1 and done=0. Results are level-valid while done is high.
interface truth_table_checker_if
  import truth_table_checker_pkg::*;
#(
  parameter int N_IN = 3
);

  localparam int NUM_VEC = num_vectors(N_IN);

  // Control / golden table, driven by the master
  logic                start;
  logic [NUM_VEC-1:0]  expected;

  // DUT stimulus and response
  logic [N_IN-1:0]     vec_out;
  logic                z_in;

  // Status and results, driven by the checker
  logic                busy;
  logic                done;
  logic                pass;
  logic [NUM_VEC-1:0]  captured;
  logic [N_IN:0]       mismatch_cnt;
  logic [N_IN-1:0]     first_fail_idx;
  logic                fail_valid;
  state_t              dbg_state;

  modport master (
    output start,
    output expected,
    output z_in,
    input  vec_out,
    input  busy,
    input  done,
    input  pass,
    input  captured,
    input  mismatch_cnt,
    input  first_fail_idx,
    input  fail_valid,
    input  dbg_state
  );

  modport slave (
    input  start,
    input  expected,
    input  z_in,
    output vec_out,
    output busy,
    output done,
    output pass,
    output captured,
    output mismatch_cnt,
    output first_fail_idx,
    output fail_valid,
    output dbg_state
  );

endinterface

// File: rtl/truth_table_checker_dwell_counter.sv
// Dwell counter: counts clock edges spent on the current vector and raises
// 'last' during the final held cycle, which is the cycle on which the DUT
// response is sampled. Wraps back to zero after the last cycle so the next
// vector starts a fresh dwell without any extra clear.
module dwell_counter #(
  parameter int HOLD_CYCLES = 20
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic last
);

  // A single-cycle hold still needs a 1-bit register to stay legal.
  localparam int CW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [CW-1:0] LAST_CNT = CW'(HOLD_CYCLES - 1);

  logic [CW-1:0] r_cnt;

  // Strobe is purely a decode of the registered count.
  assign last = (r_cnt == LAST_CNT);

  // Count held cycles; wrap on the sample cycle, hold at zero when cleared.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (clr) begin
      r_cnt <= '0;
    end else if (en) begin
      if (last) begin
        r_cnt <= '0;
      end else begin
        r_cnt <= r_cnt + CW'(1);
      end
    end
  end

endmodule

// File: rtl/truth_table_checker.sv
// Truth-table checker: applies every input vector of a small combinational
// DUT in ascending order, holds each for HOLD_CYCLES clocks, samples the
// DUT output on the final held cycle, and compares the captured table with
// a golden table latched when the run starts. Reports mismatch count, the
// lowest failing vector and an overall pass flag. All outputs are registered.
module truth_table_checker
  import truth_table_checker_pkg::*;
#(
  parameter int N_IN        = 3,
  parameter int HOLD_CYCLES = 20
) (
  input  logic                 clk,
  input  logic                 rst_n,
  truth_table_checker_if.slave bus
);

  localparam int NUM_VEC = num_vectors(N_IN);
  localparam logic [N_IN-1:0] LAST_IDX = N_IN'(NUM_VEC - 1);

  // Registered state and outputs
  state_t              r_state;
  logic [NUM_VEC-1:0]  r_exp;
  logic [N_IN-1:0]     r_idx;
  logic [N_IN-1:0]     r_vec_out;
  logic                r_busy;
  logic                r_done;
  logic                r_pass;
  logic [NUM_VEC-1:0]  r_captured;
  logic [N_IN:0]       r_mismatch_cnt;
  logic [N_IN-1:0]     r_first_fail_idx;
  logic                r_fail_valid;

  // Combinational helpers
  logic                w_accept;
  logic                w_last;
  logic                w_sample;
  logic                w_exp_bit;
  logic                w_mismatch;
  logic                w_is_last_vec;
  logic [N_IN:0]       w_mm_next;
  logic                w_dwell_clr;
  logic                w_dwell_en;

  // The dwell counter only runs while vectors are driven; outside DRIVE it
  // is held at zero so every run begins with a full dwell on vector 0.
  assign w_dwell_clr = (r_state != ST_DRIVE);
  assign w_dwell_en  = (r_state == ST_DRIVE);

  dwell_counter #(
    .HOLD_CYCLES (HOLD_CYCLES)
  ) u_dwell (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (w_dwell_clr),
    .en    (w_dwell_en),
    .last  (w_last)
  );

  // Start is honoured only when no run is in progress.
  assign w_accept = bus.start && ((r_state == ST_IDLE) || (r_state == ST_DONE));

  // Sample strobe: final held cycle of the current vector.
  assign w_sample = (r_state == ST_DRIVE) && w_last;

  // Case-inequality so an undriven or unknown DUT output counts as a miss.
  assign w_exp_bit     = r_exp[r_idx];
  assign w_mismatch    = (bus.z_in !== w_exp_bit);
  assign w_is_last_vec = (r_idx == LAST_IDX);

  // Count including the vector sampled this cycle; used for the pass flag
  // on the final vector so pass reflects the complete table.
  assign w_mm_next = r_mismatch_cnt + {{N_IN{1'b0}}, w_mismatch};

  // Main FSM with index counter, capture, compare and first-fail tracking.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state          <= ST_IDLE;
      r_exp            <= '0;
      r_idx            <= '0;
      r_vec_out        <= '0;
      r_busy           <= 1'b0;
      r_done           <= 1'b0;
      r_pass           <= 1'b0;
      r_captured       <= '0;
      r_mismatch_cnt   <= '0;
      r_first_fail_idx <= '0;
      r_fail_valid     <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE, ST_DONE: begin
          if (w_accept) begin
            r_state          <= ST_DRIVE;
            r_exp            <= bus.expected;
            r_idx            <= '0;
            r_vec_out        <= '0;
            r_busy           <= 1'b1;
            r_done           <= 1'b0;
            r_pass           <= 1'b0;
            r_captured       <= '0;
            r_mismatch_cnt   <= '0;
            r_first_fail_idx <= '0;
            r_fail_valid     <= 1'b0;
          end
        end

        ST_DRIVE: begin
          if (w_sample) begin
            r_captured[r_idx] <= bus.z_in;
            if (w_mismatch) begin
              r_mismatch_cnt <= w_mm_next;
              if (!r_fail_valid) begin
                r_first_fail_idx <= r_idx;
                r_fail_valid     <= 1'b1;
              end
            end
            if (w_is_last_vec) begin
              r_state   <= ST_DONE;
              r_busy    <= 1'b0;
              r_done    <= 1'b1;
              r_pass    <= (w_mm_next == '0);
              r_vec_out <= '0;
            end else begin
              r_idx     <= r_idx + 1'b1;
              r_vec_out <= r_idx + 1'b1;
            end
          end
        end

        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.vec_out        = r_vec_out;
  assign bus.busy           = r_busy;
  assign bus.done           = r_done;
  assign bus.pass           = r_pass;
  assign bus.captured       = r_captured;
  assign bus.mismatch_cnt   = r_mismatch_cnt;
  assign bus.first_fail_idx = r_first_fail_idx;
  assign bus.fail_valid     = r_fail_valid;
  assign bus.dbg_state      = r_state;

endmodule

// File: tb/tb_truth_table_checker.sv
// Bench for truth_table_checker: one 3-input/20-cycle instance and one
// 2-input/1-cycle instance. The DUT-under-check is modelled as a lookup
// table indexed by vec_out; expected results come from table arithmetic.
module tb_truth_table_checker;

  localparam int NA = 8;   // vectors, instance A
  localparam int HA = 20;  // hold cycles, instance A
  localparam int NB = 4;   // vectors, instance B

  logic clk = 1'b0;
  logic rst_n;

  int n_assert = 0;
  int n_fail   = 0;

  logic [7:0] tbl_a;
  logic [3:0] tbl_b;

  truth_table_checker_if #(.N_IN(3)) bus_a ();
  truth_table_checker_if #(.N_IN(2)) bus_b ();

  // Behavioural combinational DUTs: response = table[vector]
  assign bus_a.z_in = tbl_a[bus_a.vec_out];
  assign bus_b.z_in = tbl_b[bus_b.vec_out];

  truth_table_checker #(.N_IN(3), .HOLD_CYCLES(20)) u_dut_a (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_a)
  );

  truth_table_checker #(.N_IN(2), .HOLD_CYCLES(1)) u_dut_b (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_b)
  );

  // Clock
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Truth table of an N-input XOR, built from parity of each index.
  function automatic logic [7:0] xor_table();
    logic [7:0] t;
    for (int i = 0; i < NA; i++) t[i] = ^(i[2:0]);
    return t;
  endfunction

  task automatic chk_zero_a(input string tag);
    chk({tag, "_busy"}, bus_a.busy, 0);
    chk({tag, "_done"}, bus_a.done, 0);
    chk({tag, "_pass"}, bus_a.pass, 0);
    chk({tag, "_vec"},  bus_a.vec_out, 0);
    chk({tag, "_cap"},  bus_a.captured, 0);
    chk({tag, "_mm"},   bus_a.mismatch_cnt, 0);
    chk({tag, "_ff"},   bus_a.first_fail_idx, 0);
    chk({tag, "_fv"},   bus_a.fail_valid, 0);
    chk({tag, "_st"},   bus_a.dbg_state, 0);
  endtask

  // Pulse start on A (accepted at edge E0), check the cleared run state.
  task automatic start_a(input string tag, input logic [7:0] e);
    bus_a.expected = e;
    bus_a.start    = 1'b1;
    tick();
    bus_a.start    = 1'b0;
    chk({tag, "_s_busy"}, bus_a.busy, 1);
    chk({tag, "_s_done"}, bus_a.done, 0);
    chk({tag, "_s_pass"}, bus_a.pass, 0);
    chk({tag, "_s_vec"},  bus_a.vec_out, 0);
    chk({tag, "_s_cap"},  bus_a.captured, 0);
    chk({tag, "_s_mm"},   bus_a.mismatch_cnt, 0);
    chk({tag, "_s_fv"},   bus_a.fail_valid, 0);
    chk({tag, "_s_st"},   bus_a.dbg_state, 1);
  endtask

  // Walk edges 1..NA*HA; after edge k the vector on the pins is k/HA until
  // the final edge, where done rises and vec_out returns to 0.
  // Optional disturbances: a start pulse seen at edge gs, expected zeroed at edge ge.
  task automatic walk_a(input string tag, input int gs, input int ge);
    for (int k = 1; k <= NA * HA; k++) begin
      bus_a.start = (k == gs);
      if (k == ge) bus_a.expected = '0;
      tick();
      bus_a.start = 1'b0;
      if (k < NA * HA) begin
        chk({tag, "_w_vec"},  bus_a.vec_out, k / HA);
        chk({tag, "_w_busy"}, bus_a.busy, 1);
        chk({tag, "_w_done"}, bus_a.done, 0);
      end else begin
        chk({tag, "_w_enddone"}, bus_a.done, 1);
        chk({tag, "_w_endbusy"}, bus_a.busy, 0);
        chk({tag, "_w_endvec"},  bus_a.vec_out, 0);
        chk({tag, "_w_endst"},   bus_a.dbg_state, 2);
      end
    end
  endtask

  // Reference: result follows from expected XOR actual table.
  task automatic check_a(input string tag, input logic [7:0] e, input logic [7:0] t);
    logic [7:0] diff;
    int cnt;
    int first;
    diff  = e ^ t;
    cnt   = $countones(diff);
    first = 0;
    for (int i = NA - 1; i >= 0; i--) if (diff[i]) first = i;
    chk({tag, "_cap"},  bus_a.captured, t);
    chk({tag, "_mm"},   bus_a.mismatch_cnt, cnt);
    chk({tag, "_fv"},   bus_a.fail_valid, (cnt != 0));
    chk({tag, "_ff"},   bus_a.first_fail_idx, first);
    chk({tag, "_pass"}, bus_a.pass, (cnt == 0));
    chk({tag, "_done"}, bus_a.done, 1);
  endtask

  // Full run on B (hold 1): vectors 0..3 seen at edges 1..4, done at edge 4.
  task automatic run_b(input string tag, input logic [3:0] e, input logic [3:0] t);
    logic [3:0] diff;
    int cnt;
    int first;
    tbl_b          = t;
    bus_b.expected = e;
    bus_b.start    = 1'b1;
    tick();
    bus_b.start    = 1'b0;
    chk({tag, "_s_vec"},  bus_b.vec_out, 0);
    chk({tag, "_s_busy"}, bus_b.busy, 1);
    for (int k = 1; k <= NB; k++) begin
      tick();
      if (k < NB) begin
        chk({tag, "_w_vec"},  bus_b.vec_out, k);
        chk({tag, "_w_done"}, bus_b.done, 0);
      end else begin
        chk({tag, "_w_enddone"}, bus_b.done, 1);
        chk({tag, "_w_endvec"},  bus_b.vec_out, 0);
      end
    end
    diff  = e ^ t;
    cnt   = $countones(diff);
    first = 0;
    for (int i = NB - 1; i >= 0; i--) if (diff[i]) first = i;
    chk({tag, "_cap"},  bus_b.captured, t);
    chk({tag, "_mm"},   bus_b.mismatch_cnt, cnt);
    chk({tag, "_fv"},   bus_b.fail_valid, (cnt != 0));
    chk({tag, "_ff"},   bus_b.first_fail_idx, first);
    chk({tag, "_pass"}, bus_b.pass, (cnt == 0));
  endtask

  initial begin
    logic [7:0] re;
    logic [7:0] rt;

    // Reset
    rst_n          = 1'b0;
    bus_a.start    = 1'b0;
    bus_a.expected = '0;
    bus_b.start    = 1'b0;
    bus_b.expected = '0;
    tbl_a          = '0;
    tbl_b          = '0;
    tick();
    tick();
    chk_zero_a("rst_a");
    chk("rst_b_busy", bus_b.busy, 0);
    chk("rst_b_done", bus_b.done, 0);
    chk("rst_b_cap",  bus_b.captured, 0);
    rst_n = 1'b1;
    tick();
    chk_zero_a("idle_a");

    // XOR3 against its own table: full pass
    tbl_a = xor_table();
    start_a("t1", 8'h96);
    walk_a("t1", 0, 0);
    check_a("t1", 8'h96, tbl_a);

    // Output stuck at 0: four misses, first at vector 1
    tbl_a = 8'h00;
    start_a("t2", 8'h96);
    walk_a("t2", 0, 0);
    check_a("t2", 8'h96, 8'h00);
    chk("t2_ff_lit", bus_a.first_fail_idx, 1);
    chk("t2_mm_lit", bus_a.mismatch_cnt, 4);

    // Restart from DONE with a correct DUT: results cleared, then pass
    tbl_a = xor_table();
    start_a("t5", 8'h96);
    walk_a("t5", 0, 0);
    check_a("t5", 8'h96, tbl_a);

    // Start pulse at edge 50 and expected change at edge 60 are ignored
    start_a("t3", 8'h96);
    walk_a("t3", 50, 60);
    check_a("t3", 8'h96, tbl_a);

    // Reset for one edge at edge 75 abandons the run
    start_a("t4", 8'h96);
    for (int k = 1; k < 75; k++) tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk_zero_a("t4_rst");
    tick();
    chk_zero_a("t4_idle");
    start_a("t4r", 8'h96);
    walk_a("t4r", 0, 0);
    check_a("t4r", 8'h96, tbl_a);

    // Every vector misses: counter reaches its maximum without wrapping
    tbl_a = 8'hFF;
    start_a("max", 8'h00);
    walk_a("max", 0, 0);
    check_a("max", 8'h00, 8'hFF);
    chk("max_mm_lit", bus_a.mismatch_cnt, 8);

    // Random tables, golden and actual drawn independently
    for (int r = 0; r < 4; r++) begin
      re = 8'($urandom_range(0, 255));
      rt = 8'($urandom_range(0, 255));
      if (r == 1) rt = re;
      tbl_a = rt;
      start_a("rnd", re);
      walk_a("rnd", 0, 0);
      check_a("rnd", re, rt);
    end

    // Two-input AND with single-cycle hold
    run_b("t6", 4'b1000, 4'b1000);
    chk("t6_pass_lit", bus_b.pass, 1);
    for (int r = 0; r < 3; r++) begin
      run_b("rndb", 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
